// File: rtl/dsd.sv
// PCM-to-DSD converter: second-order Boser-Wooley sigma-delta modulator.
// Advances one output bit per i_bit_en tick; saturating integrators raise a sticky o_sat.
module dsd #(
  parameter int   AUDIO_WIDTH  = 24,
  parameter logic FIXED_COEFFS = 1'b1,
  parameter int   COEFF_WIDTH  = 16,
  parameter int   ACC_WIDTH    = AUDIO_WIDTH + 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_bit_en,
  input  logic [AUDIO_WIDTH-1:0] i_pcm,
  input  logic                   i_pcm_valid,
  input  logic                   i_coeff_we,
  input  logic [COEFF_WIDTH-1:0] i_coeff_b1,
  input  logic [COEFF_WIDTH-1:0] i_coeff_b2,
  output logic                   o_dsd,
  output logic                   o_dsd_valid,
  output logic                   o_sat
);
  localparam int DIFF_W = ACC_WIDTH + 1;
  localparam int PROD_W = ACC_WIDTH + COEFF_WIDTH + 1;
  localparam int FRAC   = 14;
  localparam logic signed [COEFF_WIDTH-1:0] COEFF_DEF = COEFF_WIDTH'(8192);
  localparam logic signed [ACC_WIDTH-1:0]   FS_POS    = ACC_WIDTH'(1) << (AUDIO_WIDTH - 1);
  localparam logic signed [ACC_WIDTH-1:0]   FS_NEG    = -FS_POS;
  localparam logic signed [ACC_WIDTH-1:0]   ACC_MAX   = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0]   ACC_MIN   = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic signed [AUDIO_WIDTH-1:0] x_reg;
  logic signed [ACC_WIDTH-1:0]   s1_reg, s2_reg, s1_next, s2_next, fb;
  logic signed [COEFF_WIDTH-1:0] b1_reg, b2_reg;
  logic signed [DIFF_W-1:0]      diff1, diff2;
  logic signed [PROD_W-1:0]      sum1, sum2;
  logic                          dsd_reg, valid_reg, sat_reg, clip1, clip2;

  function automatic logic signed [ACC_WIDTH-1:0] clamp(input logic signed [PROD_W-1:0] v);
    if (v > PROD_W'(ACC_MAX))
      clamp = ACC_MAX;
    else if (v < PROD_W'(ACC_MIN))
      clamp = ACC_MIN;
    else
      clamp = v[ACC_WIDTH-1:0];
  endfunction

  function automatic logic clipped(input logic signed [PROD_W-1:0] v);
    clipped = (v > PROD_W'(ACC_MAX)) || (v < PROD_W'(ACC_MIN));
  endfunction

  // Both integrator updates are evaluated in one cycle; the second stage sees s1's new value.
  always_comb begin
    fb      = dsd_reg ? FS_POS : FS_NEG;
    diff1   = DIFF_W'(x_reg) - DIFF_W'(fb);
    sum1    = PROD_W'(s1_reg) + ((PROD_W'(b1_reg) * PROD_W'(diff1)) >>> FRAC);
    s1_next = clamp(sum1);
    clip1   = clipped(sum1);
    diff2   = DIFF_W'(s1_next) - DIFF_W'(fb);
    sum2    = PROD_W'(s2_reg) + ((PROD_W'(b2_reg) * PROD_W'(diff2)) >>> FRAC);
    s2_next = clamp(sum2);
    clip2   = clipped(sum2);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_reg     <= '0;
      s1_reg    <= '0;
      s2_reg    <= '0;
      dsd_reg   <= 1'b0;
      valid_reg <= 1'b0;
      sat_reg   <= 1'b0;
      b1_reg    <= COEFF_DEF;
      b2_reg    <= COEFF_DEF;
    end else begin
      if (i_pcm_valid)
        x_reg <= i_pcm;
      // With fixed coefficients the write path is dead and the registers stay at reset value.
      if (!FIXED_COEFFS && i_coeff_we) begin
        b1_reg <= i_coeff_b1;
        b2_reg <= i_coeff_b2;
      end
      valid_reg <= i_bit_en;
      if (i_bit_en) begin
        s1_reg  <= s1_next;
        s2_reg  <= s2_next;
        dsd_reg <= ~s2_next[ACC_WIDTH-1];
        if (clip1 || clip2)
          sat_reg <= 1'b1;
      end
    end
  end

  assign o_dsd       = dsd_reg;
  assign o_dsd_valid = valid_reg;
  assign o_sat       = sat_reg;
endmodule

// File: tb/tb_dsd.sv
// Self-checking bench for dsd: a fixed-coefficient and a programmable instance share stimulus;
// a longint reference model queues expected bits that are popped on every o_dsd_valid.
`timescale 1ns/1ps
module tb_dsd;
  localparam longint FS      = 64'sd1 <<< 23;
  localparam longint ACC_MAX = (64'sd1 <<< 31) - 1;
  localparam longint ACC_MIN = -(64'sd1 <<< 31);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_en = 1'b0, pcm_valid = 1'b0, coeff_we = 1'b0;
  logic [23:0] pcm = '0;
  logic [15:0] c1 = '0, c2 = '0;
  logic        dsd_f, val_f, sat_f, dsd_v, val_v, sat_v;

  always #5 clk = ~clk;

  dsd #(.AUDIO_WIDTH(24), .FIXED_COEFFS(1'b1), .COEFF_WIDTH(16), .ACC_WIDTH(32)) dut_fix (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit_en(bit_en), .i_pcm(pcm), .i_pcm_valid(pcm_valid),
    .i_coeff_we(coeff_we), .i_coeff_b1(c1), .i_coeff_b2(c2),
    .o_dsd(dsd_f), .o_dsd_valid(val_f), .o_sat(sat_f));

  dsd #(.AUDIO_WIDTH(24), .FIXED_COEFFS(1'b0), .COEFF_WIDTH(16), .ACC_WIDTH(32)) dut_var (
    .i_clk(clk), .i_rst_n(rst_n), .i_bit_en(bit_en), .i_pcm(pcm), .i_pcm_valid(pcm_valid),
    .i_coeff_we(coeff_we), .i_coeff_b1(c1), .i_coeff_b2(c2),
    .o_dsd(dsd_v), .o_dsd_valid(val_v), .o_sat(sat_v));

  typedef struct packed { logic dsd; logic sat; } exp_t;
  typedef struct { longint x; int ticks; int gap; int lo; int hi; string name; } vec_t;

  exp_t   q_fix[$], q_var[$];
  longint ms1[2], ms2[2], mb1[2], mb2[2], mx;
  bit     mdsd[2], msat[2];
  int     n_vec = 0, n_err = 0, ones_fix = 0, ones_var = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms1[k] = 0; ms2[k] = 0; mb1[k] = 8192; mb2[k] = 8192; mdsd[k] = 1'b0; msat[k] = 1'b0;
    end
    mx = 0;
    q_fix.delete();
    q_var.delete();
  endtask

  task automatic model_tick(input int k);
    longint fb, s1n, s2n;
    exp_t e;
    fb  = mdsd[k] ? FS : -FS;
    s1n = ms1[k] + ((mb1[k] * (mx - fb)) >>> 14);
    if (s1n > ACC_MAX) begin s1n = ACC_MAX; msat[k] = 1'b1; end
    else if (s1n < ACC_MIN) begin s1n = ACC_MIN; msat[k] = 1'b1; end
    s2n = ms2[k] + ((mb2[k] * (s1n - fb)) >>> 14);
    if (s2n > ACC_MAX) begin s2n = ACC_MAX; msat[k] = 1'b1; end
    else if (s2n < ACC_MIN) begin s2n = ACC_MIN; msat[k] = 1'b1; end
    ms1[k] = s1n; ms2[k] = s2n; mdsd[k] = (s2n >= 0);
    e.dsd = mdsd[k]; e.sat = msat[k];
    if (k == 0) q_fix.push_back(e); else q_var.push_back(e);
  endtask

  // Called once per negedge: every valid pulse must match the next queued expectation.
  task automatic observe();
    exp_t e;
    if (val_f) begin
      if (q_fix.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL fix_spurious_valid: o_dsd_valid=1, required 0");
      end else begin
        e = q_fix.pop_front();
        check("fix dsd/sat", {dsd_f, sat_f}, e);
        if (dsd_f) ones_fix++;
      end
    end
    if (val_v) begin
      if (q_var.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL var_spurious_valid: o_dsd_valid=1, required 0");
      end else begin
        e = q_var.pop_front();
        check("var dsd/sat", {dsd_v, sat_v}, e);
        if (dsd_v) ones_var++;
      end
    end
  endtask

  task automatic step(input bit en, input bit pv, input longint p, input bit we,
                      input longint w1, input longint w2);
    @(negedge clk);
    observe();
    bit_en = en; pcm_valid = pv; pcm = p[23:0]; coeff_we = we; c1 = w1[15:0]; c2 = w2[15:0];
    if (en) begin model_tick(0); model_tick(1); end
    if (pv) mx = p;
    if (we) begin mb1[1] = w1; mb2[1] = w2; end
  endtask

  task automatic tick();
    step(1'b1, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, 1'b0, 0, 0);
  endtask

  task automatic drain(input string tag);
    idle(2);
    check({tag, " fix pending"}, q_fix.size(), 0);
    check({tag, " var pending"}, q_var.size(), 0);
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    observe();
    #2;
    rst_n = 1'b0; bit_en = 1'b0; pcm_valid = 1'b0; coeff_we = 1'b0;
    #1;
    if (chk) begin
      check("rst o_dsd", dsd_f, 0);
      check("rst o_dsd_valid", val_f, 0);
      check("rst o_sat", sat_f, 0);
      check("rst s1", dut_fix.s1_reg, 0);
      check("rst s2", dut_fix.s2_reg, 0);
      check("rst var b2", dut_var.b2_reg, 8192);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // x = 0 from reset: hand-derived first tick, one-cycle valid, then ~50% density.
  task automatic first_scenario(input string tag, input bit rst, input bit wzero);
    int base;
    if (rst) do_reset(1'b1);
    if (wzero) step(1'b0, 1'b0, 0, 1'b1, 0, 0);
    tick();
    @(posedge clk); #1;
    check({tag, " s1 tick1"}, dut_fix.s1_reg, 64'sd1 <<< 22);
    check({tag, " s2 tick1"}, dut_fix.s2_reg, 3 * (64'sd1 <<< 21));
    check({tag, " dsd tick1"}, dsd_f, 1);
    check({tag, " valid tick1"}, val_f, 1);
    base = ones_fix;
    idle(1);
    @(posedge clk); #1;
    check({tag, " valid idle"}, val_f, 0);
    check({tag, " s1 hold"}, dut_fix.s1_reg, 64'sd1 <<< 22);
    repeat (1023) tick();
    drain(tag);
    check_range({tag, " ones/1024"}, ones_fix - base + 1, 510, 514);
    check({tag, " o_sat"}, sat_f, 0);
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{x: 0,            ticks: 1024, gap: 0, lo: 510,  hi: 514,  name: "x0"};
    vecs[1] = '{x: 64'sd4194304, ticks: 4096, gap: 0, lo: 3032, hi: 3112, name: "x+half"};
    vecs[2] = '{x: -64'sd4194304, ticks: 4096, gap: 0, lo: 984, hi: 1064, name: "x-half"};
    vecs[3] = '{x: 0,            ticks: 512,  gap: 1, lo: 252,  hi: 260,  name: "x0 gapped"};
    model_reset();

    first_scenario("scn1", 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      int base;
      do_reset(1'b0);
      step(1'b0, 1'b1, vecs[i].x, 1'b0, 0, 0);
      base = ones_fix;
      for (int t = 0; t < vecs[i].ticks; t++) begin
        tick();
        if (vecs[i].gap > 0) idle(vecs[i].gap);
      end
      drain(vecs[i].name);
      check_range({vecs[i].name, " ones"}, ones_fix - base, vecs[i].lo, vecs[i].hi);
      check({vecs[i].name, " o_sat"}, sat_f, 0);
    end

    // New sample loaded on a tick cycle: that tick still uses x = 0.
    do_reset(1'b0);
    step(1'b1, 1'b1, 64'sd1 <<< 22, 1'b0, 0, 0);
    @(posedge clk); #1;
    check("coincident pcm s1", dut_fix.s1_reg, 64'sd1 <<< 22);
    tick();
    @(posedge clk); #1;
    check("next tick s1", dut_fix.s1_reg, 64'sd1 <<< 21);
    drain("coincident pcm");

    // Coefficient write on a tick cycle applies from the following tick.
    do_reset(1'b0);
    step(1'b1, 1'b0, 0, 1'b1, 0, 0);
    tick();
    @(posedge clk); #1;
    check("coef coincident s1", dut_var.s1_reg, 64'sd1 <<< 22);
    check("coef coincident s2", dut_var.s2_reg, 3 * (64'sd1 <<< 21));
    drain("coincident coef");

    // b2 = 0: a priming tick at x = -FS leaves s1 = 0 with o_dsd = 1, then s1 ramps down.
    do_reset(1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 8192, 0);
    step(1'b0, 1'b1, -(64'sd1 <<< 23), 1'b0, 0, 0);
    tick();
    @(posedge clk); #1;
    check("prime s1", dut_var.s1_reg, 0);
    check("prime dsd", dsd_v, 1);
    step(1'b0, 1'b1, 64'sd1 <<< 22, 1'b0, 0, 0);
    for (int j = 1; j <= 1025; j++) begin
      tick();
      if (j == 1 || j == 1024 || j == 1025) begin
        @(posedge clk); #1;
        check($sformatf("ramp s1 tick%0d", j), dut_var.s1_reg, (j == 1) ? -(64'sd1 <<< 21) : ACC_MIN);
        check($sformatf("ramp o_sat tick%0d", j), sat_v, (j == 1025) ? 1 : 0);
        check($sformatf("ramp dsd tick%0d", j), dsd_v, 1);
      end
    end
    step(1'b1, 1'b1, 0, 1'b0, 0, 0);
    repeat (5) tick();
    @(posedge clk); #1;
    check("sat sticky", sat_v, 1);
    drain("saturation");

    // Asynchronous reset between edges clears outputs before the next clock edge.
    do_reset(1'b0);
    repeat (300) tick();
    @(posedge clk); #2;
    check("mid valid pre", val_f, 1);
    rst_n = 1'b0; bit_en = 1'b0;
    #1;
    check("mid valid", val_f, 0);
    check("mid dsd", dsd_f, 0);
    check("mid s1", dut_fix.s1_reg, 0);
    check("mid s2", dut_fix.s2_reg, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    first_scenario("after rst", 1'b0, 1'b0);

    // Writes to the fixed instance are ignored.
    first_scenario("fixed ignore", 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1);
  end
endmodule

// File: doc/dsd.md
Name: dsd

Overview:
- PCM-to-DSD converter: 2nd-order Boser-Wooley sigma-delta modulator.
- Converts a signed PCM stream into a 1-bit pulse-density stream, advancing one bit per oversampling tick.
- Sits between the audio input path and the 1-bit output/DSD serializer.
- Loop coefficients are either built-in constants or runtime-programmable, selected by parameter.

Parameters:
- AUDIO_WIDTH, 24: PCM sample width, signed two's complement.
- FIXED_COEFFS, 1'b1: 1 = constant coefficients (b1 = b2 = 8192), coefficient ports ignored; 0 = coefficients held in registers writable via ports.
- COEFF_WIDTH, 16: signed coefficient width, Q1.14 format (8192 = 0.5).
- ACC_WIDTH, AUDIO_WIDTH+8: integrator width, signed, saturating.

Ports:
- i_clk, in, 1: system clock, all logic on rising edge.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_bit_en, in, 1: oversampling tick; modulator advances one bit per cycle it is high.
- i_pcm, in, AUDIO_WIDTH: signed PCM sample.
- i_pcm_valid, in, 1: loads i_pcm into the held-sample register.
- i_coeff_we, in, 1: coefficient write strobe (FIXED_COEFFS=0 only).
- i_coeff_b1, in, COEFF_WIDTH: first-integrator gain.
- i_coeff_b2, in, COEFF_WIDTH: second-integrator gain.
- o_dsd, out, 1: DSD bit; 1 = +full scale, 0 = -full scale.
- o_dsd_valid, out, 1: one-cycle pulse marking a new o_dsd.
- o_sat, out, 1: sticky; set when either integrator saturates.

Behaviour:
- Reset (async assert, sync-released use):
  - s1, s2, held sample x, o_dsd, o_dsd_valid, o_sat all 0.
  - b1, b2 registers = 8192.
  - Reset mid-stream discards all loop state immediately.
- Sample hold:
  - x <= i_pcm on any cycle with i_pcm_valid; zero-order hold between loads.
  - Input is always accepted; there is no ready signal.
- Feedback value: fb = +FS when o_dsd=1, -FS when o_dsd=0, with FS = 2^(AUDIO_WIDTH-1). fb is sign-extended to ACC_WIDTH.
- On a cycle with i_bit_en=1, using the current x, s1, s2 and o_dsd:
  - s1n = sat(s1 + ((b1*(x - fb)) >>> 14))
  - s2n = sat(s2 + ((b2*(s1n - fb)) >>> 14))
  - s1 <= s1n; s2 <= s2n; o_dsd <= (s2n >= 0); o_dsd_valid <= 1.
- Arithmetic rules:
  - Products are full precision (ACC_WIDTH+COEFF_WIDTH+1 bits).
  - >>> is an arithmetic shift (floor).
  - sat() clamps to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1].
  - Clamping sets o_sat, which stays 1 until reset.
- Latency: o_dsd and o_dsd_valid update at the edge that samples i_bit_en, so they are visible the cycle after the tick.
- o_dsd_valid = 0 on cycles without a tick. Back-to-back ticks give consecutive valid pulses.
- Without a tick, all loop state holds.
- Simultaneous i_pcm_valid and i_bit_en: the tick uses the old x; the new sample applies from the next tick.
- Coefficients:
  - FIXED_COEFFS=0: b1 <= i_coeff_b1 and b2 <= i_coeff_b2 on i_coeff_we.
  - A write coincident with a tick takes effect on the next tick.
  - FIXED_COEFFS=1: i_coeff_* and i_coeff_we are ignored.

Test Plan:
- Reset, x=0, default coeffs, first tick:
  - s1 = 2^22, s2 = 3*2^21, o_dsd = 1, o_dsd_valid pulses one cycle.
  - Over 1024 ticks, count of ones = 512 ±2.
- x = +2^22 (half scale), 4096 ticks -> ones density 75% ±1%. x = -2^22 -> 25% ±1%. o_sat stays 0.
- FIXED_COEFFS=0, write b2=0, x=+2^22:
  - o_dsd stays 1; s1 falls by 2^21 per tick.
  - s1 clamps at -2^31 and o_sat rises on tick 1025; o_sat stays set after x is reset to 0.
- i_pcm_valid and i_bit_en in the same cycle with x changing 0 -> +2^22: that tick's s1 update uses x=0.
- Assert i_rst_n low mid-stream between edges:
  - Outputs clear immediately, without waiting for a clock edge.
  - After release, the sequence repeats the first scenario exactly.
- FIXED_COEFFS=1: write b1=b2=0 -> ignored; output identical to the first scenario.
